// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit: sequences each instruction through fetch, decode,
// execute, memory and write-back, and drives the ULA operation and datapath enables.
module controle_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrucao,
  input  logic        igual,
  output logic [3:0]  operacao,
  output logic        ula_fonte_b,
  output logic        pc_escreve,
  output logic [1:0]  pc_fonte,
  output logic        ir_escreve,
  output logic        reg_escreve,
  output logic        reg_destino,
  output logic        mem_para_reg,
  output logic        mem_le,
  output logic        mem_escreve,
  output logic        parado,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    BUSCA      = 3'b000,
    DECODIFICA = 3'b001,
    EXECUTA    = 3'b010,
    MEMORIA    = 3'b011,
    ESCRITA    = 3'b100,
    PARADO     = 3'b101
  } estado_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_JUMP = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;
  localparam logic [5:0] OP_SLTI = 6'b001000;

  estado_t    state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [3:0] funct_q, funct_d;
  logic       legal;

  // Only opcode and funct are decoded here; the remaining fields feed the datapath.
  logic unused_campos;
  assign unused_campos = ^instrucao[25:4];

  always_comb begin
    legal = 1'b0;
    case (instrucao[31:26])
      OP_R:    legal = (instrucao[3:0] <= 4'd5) || (instrucao[3:0] == 4'd8) ||
                       (instrucao[3:0] == 4'd9);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_JUMP, OP_HALT, OP_SLTI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= BUSCA;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    operacao     = 4'b0000;
    ula_fonte_b  = 1'b0;
    pc_escreve   = 1'b0;
    pc_fonte     = 2'b00;
    ir_escreve   = 1'b0;
    reg_escreve  = 1'b0;
    reg_destino  = 1'b0;
    mem_para_reg = 1'b0;
    mem_le       = 1'b0;
    mem_escreve  = 1'b0;
    parado       = 1'b0;
    estado       = state_q;

    case (state_q)
      BUSCA: begin
        ir_escreve = 1'b1;
        pc_escreve = 1'b1;
        state_d    = DECODIFICA;
      end
      DECODIFICA: begin
        opcode_d = instrucao[31:26];
        funct_d  = instrucao[3:0];
        if (!legal || instrucao[31:26] == OP_HALT) state_d = PARADO;
        else                                       state_d = EXECUTA;
      end
      EXECUTA: begin
        state_d = BUSCA;
        case (opcode_q)
          OP_R:    begin operacao = funct_q; state_d = ESCRITA; end
          OP_ADDI: begin ula_fonte_b = 1'b1; state_d = ESCRITA; end
          OP_SLTI: begin operacao = 4'b1000; ula_fonte_b = 1'b1; state_d = ESCRITA; end
          OP_LW, OP_SW: begin ula_fonte_b = 1'b1; state_d = MEMORIA; end
          // Branch taken decision is the only output that depends on a live input.
          OP_BEQ:  begin operacao = 4'b0110; pc_fonte = 2'b01; pc_escreve = igual; end
          OP_BNE:  begin operacao = 4'b0111; pc_fonte = 2'b01; pc_escreve = igual; end
          OP_JUMP: begin pc_fonte = 2'b10; pc_escreve = 1'b1; end
          default: state_d = BUSCA;
        endcase
      end
      MEMORIA: begin
        if (opcode_q == OP_LW) begin
          mem_le  = 1'b1;
          state_d = ESCRITA;
        end else begin
          mem_escreve = 1'b1;
          state_d     = BUSCA;
        end
      end
      ESCRITA: begin
        reg_escreve  = 1'b1;
        reg_destino  = (opcode_q == OP_R);
        mem_para_reg = (opcode_q == OP_LW);
        state_d      = BUSCA;
      end
      PARADO: begin
        parado = 1'b1;
      end
      default: state_d = BUSCA;
    endcase

    // Reset silences every output at once so no partial write escapes mid-instruction.
    if (reset) begin
      operacao     = 4'b0000;
      ula_fonte_b  = 1'b0;
      pc_escreve   = 1'b0;
      pc_fonte     = 2'b00;
      ir_escreve   = 1'b0;
      reg_escreve  = 1'b0;
      reg_destino  = 1'b0;
      mem_para_reg = 1'b0;
      mem_le       = 1'b0;
      mem_escreve  = 1'b0;
      parado       = 1'b0;
      estado       = 3'b000;
    end
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multi-cycle control unit that drives the ULA (arithmetic logic unit). It sequences each instruction through fetch, decode, execute, memory and write-back states. It generates the 4-bit `operacao` code and datapath enables, and consumes the ULA `igual` flag to resolve beq/bne. It sits between the instruction register and the datapath of the processor core.

## Interface
- No parameters; all widths are fixed by the ISA.
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of `clock`
- instrucao  in  32  instruction register output; opcode = [31:26], funct = [3:0]
- igual  in  1  ULA compare flag (combinational, valid in the same cycle as `operacao`)
- operacao  out  4  ULA operation code
- ula_fonte_b  out  1  0 = register B, 1 = immediate
- pc_escreve  out  1  PC write enable
- pc_fonte  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- ir_escreve  out  1  instruction register load
- reg_escreve  out  1  register file write enable
- reg_destino  out  1  0 = rt [20:16], 1 = rd [15:11]
- mem_para_reg  out  1  write-back source: 0 = ULA, 1 = memory
- mem_le  out  1  data memory read
- mem_escreve  out  1  data memory write
- parado  out  1  processor halted
- estado  out  3  current state, for debug

## Operation
- **Opcodes:**
  - 000000 R-type: `operacao` = funct; legal funct values are 0000–0101, 1000 and 1001.
  - 000001 addi (operacao 0000); 001000 slti (operacao 1000).
  - 000010 lw and 000011 sw (address computed with operacao 0000).
  - 000100 beq (operacao 0110); 000101 bne (operacao 0111).
  - 000110 jump; 000111 halt.
  - Any other opcode, and R-type funct 0110, 0111 or 1010–1111, is illegal.
- **States:** BUSCA=000, DECODIFICA=001, EXECUTA=010, MEMORIA=011, ESCRITA=100, PARADO=101.
- **BUSCA:** ir_escreve=1, pc_escreve=1, pc_fonte=00. Next state DECODIFICA.
- **DECODIFICA:**
  - Latch opcode and funct into internal registers from `instrucao`.
  - Illegal instruction → PARADO.
  - halt → PARADO.
  - jump → EXECUTA.
  - Otherwise → EXECUTA.
- **EXECUTA:** `operacao` comes from the latched opcode/funct. ula_fonte_b=1 for addi, slti, lw and sw.
  - R-type, addi, slti → ESCRITA.
  - lw, sw → MEMORIA.
  - beq/bne: pc_fonte=01 and pc_escreve=igual. This is the only Mealy output. Next state BUSCA.
  - jump: pc_fonte=10, pc_escreve=1. Next state BUSCA.
- **MEMORIA:** `operacao` is held at 0000.
  - lw: mem_le=1, next state ESCRITA.
  - sw: mem_escreve=1, next state BUSCA.
- **ESCRITA:** reg_escreve=1. Next state BUSCA.
  - reg_destino=1 for R-type, 0 otherwise.
  - mem_para_reg=1 for lw only.
- **PARADO:** parado=1 and every enable is 0. The state is held until `reset`.
- **Defaults:** every output not named for a state is 0, and `operacao` is 0000.
- **reset high**, including mid-instruction:
  - Next state is BUSCA and the latched opcode/funct clear to 0.
  - While reset is asserted, every output is forced to 0 (estado=000, parado=0). No partial memory or register write may leak.

## Timing
- All state and latch updates happen on the rising edge of `clock`. Outputs decode combinationally from state and latched fields.
- Latency, counted from the BUSCA cycle:
  - R-type, addi, slti: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, jump: 3 cycles.
  - halt: 2 cycles into PARADO.
- `instrucao` must be stable from the DECODIFICA cycle onward. Later changes are ignored because the fields are latched.
- `igual` is only used in EXECUTA of beq/bne. It is ignored in every other cycle.
- First BUSCA occurs in the cycle after `reset` is deasserted.

## Test plan
- **Reset:** reset=1 for 2 cycles → every output 0, estado=000; first cycle after release gives ir_escreve=1, pc_escreve=1.
- **add:** opcode 000000, funct 0000 → estado sequence 000,001,010,100. In EXECUTA, operacao=0000. In ESCRITA, reg_escreve=1, reg_destino=1.
- **lw:** opcode 000010 → 5 cycles. In EXECUTA, operacao=0000 with ula_fonte_b=1. MEMORIA gives mem_le=1. ESCRITA gives mem_para_reg=1, reg_destino=0.
- **Branches:** beq with igual=1 → EXECUTA gives operacao=0110, pc_fonte=01, pc_escreve=1. bne with igual=0 → operacao=0111, pc_escreve=0. Both return to BUSCA.
- **Halt and illegal:** halt (000111) → parado=1 from the third cycle, with no enables for 10 cycles. Illegal opcode 111111 behaves the same. Reset asserted in the MEMORIA state of sw → mem_escreve=0 in the reset cycle, then BUSCA follows.
